// File: rtl/cpu_clk_pkg.sv
// Shared types and constants for the processor run-control / clock-enable scheduler.
// The divisor table is fixed here; the top module sizes it to its DIV_WIDTH.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StStep   = 2'd2,
    StHalted = 2'd3
  } state_e;

  localparam int unsigned DivTableWidth = 28;

  localparam logic [DivTableWidth-1:0] DIV_TABLE [4] = '{
    28'd1, 28'd5, 28'd5000000, 28'd50000000
  };

  // 10 ms at a 50 MHz board clock.
  localparam int unsigned DefaultDebounceCycles = 500000;

  // A zero entry would never complete a period, so it is run as divide-by-1.
  function automatic logic [DivTableWidth-1:0] div_entry(input logic [1:0] sel);
    logic [DivTableWidth-1:0] d;
    d = DIV_TABLE[sel];
    if (d == '0) begin
      d = DivTableWidth'(1);
    end
    return d;
  endfunction

endpackage

// File: rtl/cpu_clock_ctrl_btn_debounce.sv
// Push-button level debouncer: dout follows din only after din has held a new level
// for CYCLES consecutive clocks. CYCLES must be at least 1.
module btn_debounce #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CntW-1:0] r_cnt;
  logic            r_stable;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (din == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CntW'(CYCLES - 1)) begin
      r_stable <= din;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign dout = r_stable;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Run-control scheduler producing the processor's single-cycle cpu_en strobe.
// Define CPU_CLK_CTRL_DEBOUNCE_EN to insert the step-button debouncer.
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DIV_WIDTH       = 28,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 run_sw,
  input  logic                 step_btn,
  input  logic [1:0]           div_sel,
  input  logic                 halt_req,
  output logic                 cpu_en,
  output logic                 halted,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] tick_cnt
);

  logic                 r_run_meta, r_run_sync;
  logic                 r_btn_meta, r_btn_sync;
  logic                 r_btn_prev;
  state_e               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_cpu_en;
  logic                 r_halted;
  logic [CNT_WIDTH-1:0] r_tick;

  logic                 w_btn_level;
  logic                 w_step_ev;
  logic [DIV_WIDTH-1:0] w_div_tab;
  logic [DIV_WIDTH-1:0] w_div_cur;
  logic                 w_period_end;
  state_e               w_state_nxt;
  logic [DIV_WIDTH-1:0] w_cnt_nxt;
  logic [DIV_WIDTH-1:0] w_div_nxt;
  logic                 w_cpu_en_nxt;

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  btn_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .din      (r_btn_sync),
    .dout     (w_btn_level)
  );
`else
  assign w_btn_level = r_btn_sync;
`endif

  assign w_step_ev = w_btn_level & ~r_btn_prev;

  // The divisor is only sampled at the start of a period so a period is never cut short.
  assign w_div_tab    = DIV_WIDTH'(div_entry(div_sel));
  assign w_div_cur    = (r_cnt == '0) ? w_div_tab : r_div;
  assign w_period_end = (r_cnt == w_div_cur - DIV_WIDTH'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_div_nxt    = r_div;
    w_cpu_en_nxt = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt   = '0;
        w_state_nxt = r_run_sync ? StRun : StStep;
      end
      StRun: begin
        if (halt_req) begin
          w_state_nxt = StHalted;
        end else if (!r_run_sync) begin
          w_state_nxt = StStep;
          w_cnt_nxt   = '0;
        end else begin
          w_div_nxt = w_div_cur;
          if (w_period_end) begin
            w_cpu_en_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + DIV_WIDTH'(1);
          end
        end
      end
      StStep: begin
        w_cnt_nxt = '0;
        if (halt_req) begin
          w_state_nxt = StHalted;
        end else if (r_run_sync) begin
          w_state_nxt = StRun;
        end else if (w_step_ev) begin
          w_cpu_en_nxt = 1'b1;
        end
      end
      StHalted: begin
        // Leaves on a step event even if halt_req is still held.
        if (w_step_ev) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_run_meta <= 1'b0;
      r_run_sync <= 1'b0;
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_prev <= 1'b0;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_div      <= DIV_WIDTH'(1);
      r_cpu_en   <= 1'b0;
      r_halted   <= 1'b0;
      r_tick     <= '0;
    end else begin
      r_run_meta <= run_sw;
      r_run_sync <= r_run_meta;
      r_btn_meta <= step_btn;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= w_btn_level;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div      <= w_div_nxt;
      r_cpu_en   <= w_cpu_en_nxt;
      r_halted   <= (w_state_nxt == StHalted);
      if (w_cpu_en_nxt) begin
        r_tick <= r_tick + CNT_WIDTH'(1);
      end
    end
  end

  assign cpu_en   = r_cpu_en;
  assign halted   = r_halted;
  assign state_o  = r_state;
  assign tick_cnt = r_tick;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Randomized scoreboard bench for cpu_clock_ctrl: expected strobe cycles and tick values
// are predicted from the run/step/halt rules and matched by an independent monitor.
module tb_cpu_clock_ctrl;

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif
  // Raw button rise to cpu_en: 2 sync flops, debounce hold, registered strobe.
  localparam int LAT = 3 + DB;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b0;
  logic        run_sw   = 1'b1;
  logic        step_btn = 1'b0;
  logic [1:0]  div_sel  = 2'd1;
  logic        halt_req = 1'b0;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  state_o;
  logic [15:0] tick_cnt;

  cpu_clock_ctrl #(
    .DIV_WIDTH       (28),
    .DEBOUNCE_CYCLES (8),
    .CNT_WIDTH       (16)
  ) dut (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .div_sel  (div_sel),
    .halt_req (halt_req),
    .cpu_en   (cpu_en),
    .halted   (halted),
    .state_o  (state_o),
    .tick_cnt (tick_cnt)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int cyc;
    int tick;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   exp_tick = 0;

  always @(posedge clock_in) cyc <= cyc + 1;

  function automatic int div_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return 1;
      2'd1:    return 5;
      2'd2:    return 5000000;
      default: return 50000000;
    endcase
  endfunction

  task automatic push_strobe(input int c);
    exp_tick = exp_tick + 1;
    q.push_back('{c, exp_tick % 65536});
  endtask

  task automatic check(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  // Monitor: every strobe must match the next predicted one; an overdue prediction is a miss.
  always @(negedge clock_in) begin : mon
    exp_t e;
    if (reset_n) begin
      if (cpu_en) begin
        checks = checks + 1;
        if (q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL unexpected_strobe: cpu_en=1 at cycle %0d, none expected", cyc);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.tick != int'(tick_cnt)) begin
            failures = failures + 1;
            $display("FAIL strobe: got cycle %0d tick %0d, expected cycle %0d tick %0d",
                     cyc, tick_cnt, e.cyc, e.tick);
          end
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL missing_strobe: cpu_en=0 at cycle %0d, expected strobe at cycle %0d",
                 cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  logic [1:0] plan [0:99];
  int p, r, b, h, s, e1, e2, p2, k, m, w, g, t, d, nsteps;
  localparam int L = 80;

  initial begin
    @(posedge clock_in);
    #1;
    repeat (2) @(posedge clock_in);
    #1;
    check("reset_cpu_en", int'(cpu_en), 0);
    check("reset_halted", int'(halted), 0);
    check("reset_state", int'(state_o), 0);
    check("reset_tick", int'(tick_cnt), 0);

    // Free-run: div 5 for a while, then random divisor changes between 5 and 1.
    for (int i = 0; i < 100; i++) begin
      if (i < 30) plan[i] = 2'd1;
      else if (i >= L) plan[i] = plan[L-1];
      else if ($urandom_range(0, 7) == 0) plan[i] = plan[i-1] ^ 2'd1;
      else plan[i] = plan[i-1];
    end
    p = cyc;
    r = p + L;
    t = p + 3;  // run_sw needs two sync cycles; IDLE sees 0 first, so RUN starts at p+3
    forever begin
      d = div_of(plan[t-p]);
      if (t + d > r + 2) break;
      push_strobe(t + d);
      t = t + d;
    end
    reset_n = 1'b1;
    for (int i = 0; i <= L; i++) begin
      wait_edge(p + i);
      div_sel = plan[i];
      if (i == 23) check("tick_after_20_run_cycles", int'(tick_cnt), 4);
    end
    run_sw = 1'b0;
    wait_edge(r + 4);
    check("state_step_after_run_off", int'(state_o), 2);

    // Step mode: random button pulses, one strobe per press.
    b      = r + 6;
    nsteps = $urandom_range(3, 6);
    for (int i = 0; i < nsteps; i++) begin
      w = $urandom_range(DB + 1, DB + 10);
      g = $urandom_range(DB + 2, DB + 6);
      push_strobe(b + LAT);
      wait_edge(b);
      step_btn = 1'b1;
      wait_edge(b + w);
      step_btn = 1'b0;
      b = b + w + g;
    end

    // Halt from STEP, then leave via a step event (IDLE -> STEP, no strobe).
    h = b + 2;
    wait_edge(h);
    check("state_step_before_halt", int'(state_o), 2);
    halt_req = 1'b1;
    wait_edge(h + 1);
    check("halted_from_step", int'(halted), 1);
    check("state_halted_from_step", int'(state_o), 3);
    halt_req = 1'b0;
    b = h + 3;
    wait_edge(b);
    step_btn = 1'b1;
    wait_edge(b + LAT);
    check("state_idle_after_halt_step", int'(state_o), 0);
    wait_edge(b + LAT + 1);
    check("state_step_after_idle", int'(state_o), 2);
    step_btn = 1'b0;

    // RUN at div 5, halt raised on the cycle a strobe is due.
    s = b + LAT + 4;
    wait_edge(s);
    run_sw  = 1'b1;
    div_sel = 2'd1;
    e1 = s + 3;
    k  = $urandom_range(1, 3);
    for (int j = 1; j < k; j++) push_strobe(e1 + 5 * j);
    wait_edge(e1 + 5 * k - 1);
    check("state_run_before_halt", int'(state_o), 1);
    halt_req = 1'b1;
    wait_edge(e1 + 5 * k);
    check("halted_from_run", int'(halted), 1);
    check("state_halted_from_run", int'(state_o), 3);
    wait_edge(e1 + 5 * k + 2);
    halt_req = 1'b0;

    // Resume: step event takes HALTED -> IDLE -> RUN.
    b = e1 + 5 * k + 4;
    wait_edge(b);
    step_btn = 1'b1;
    wait_edge(b + LAT);
    check("state_idle_on_resume", int'(state_o), 0);
    check("halted_clear_on_resume", int'(halted), 0);
    wait_edge(b + LAT + 1);
    check("state_run_on_resume", int'(state_o), 1);
    step_btn = 1'b0;
    e2 = b + LAT + 1;

    // Reset in the middle of a period at count 3 of 5.
    m = $urandom_range(1, 3);
    for (int j = 1; j <= m; j++) push_strobe(e2 + 5 * j);
    wait_edge(e2 + 5 * m + 3);
    reset_n = 1'b0;
    #1;
    check("midreset_cpu_en", int'(cpu_en), 0);
    check("midreset_halted", int'(halted), 0);
    check("midreset_state", int'(state_o), 0);
    check("midreset_tick", int'(tick_cnt), 0);
    exp_tick = 0;
    q.delete();
    wait_edge(e2 + 5 * m + 6);
    p2      = cyc;
    div_sel = 2'd1;
    reset_n = 1'b1;
    for (int j = 1; j <= 4; j++) push_strobe(p2 + 3 + 5 * j);
    wait_edge(p2 + 25);
    run_sw = 1'b0;
    wait_edge(p2 + 35);
    check("final_state_step", int'(state_o), 2);
    check("final_pending_strobes", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Run-control and clock-enable scheduler for the lab processor. It produces a single-cycle `cpu_en` strobe that the processor uses to qualify every register update, so the processor stays on the board clock and does not use a derived clock. The strobe comes from one of three sources: free-running at a selectable divided rate, single-step from a push-button, or halted on a processor request. The block sits between the board clock/switches and the processor core.

## Interface
- `DIV_WIDTH`, 28: width of the divide counter and of the divisor table entries.
- `DEBOUNCE_CYCLES`, 500000: stable-level cycles required on `step_btn` (10 ms at 50 MHz).
- `CNT_WIDTH`, 16: width of `tick_cnt`.

Ports:
- `clock_in` input 1: board clock. This is the block's only clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `run_sw` input 1: slide switch, asynchronous. 1 selects free-run, 0 selects step mode.
- `step_btn` input 1: raw push-button, asynchronous, active-high.
- `div_sel` input 2: index into the divisor table. Synchronous to `clock_in`.
- `halt_req` input 1: level from the processor (HALT instruction). Synchronous.
- `cpu_en` output 1: one-cycle clock-enable strobe.
- `halted` output 1: high while in HALTED.
- `state_o` output 2: current FSM state.
- `tick_cnt` output CNT_WIDTH: number of `cpu_en` strobes issued. Wraps modulo 2^CNT_WIDTH.

## Operation
- `run_sw` passes through a 2-flop synchronizer. `step_btn` passes through a 2-flop synchronizer, then the debouncer, then a rising-edge detector. The output of that chain is `step_ev`, a one-cycle pulse.
- State encoding: IDLE=0, RUN=1, STEP=2, HALTED=3.
- IDLE:
  - If synced `run_sw`=1, go to RUN; otherwise go to STEP.
  - Occupies exactly 1 cycle.
  - The divide counter is cleared here.
- RUN:
  - The counter counts 0..div-1.
  - When count==div-1 and `halt_req`=0, assert `cpu_en` and wrap the counter to 0.
  - The divisor `div` is latched from the table only when count==0, so a change on `div_sel` never truncates a period.
  - div=1 gives `cpu_en` continuously high.
  - Synced `run_sw`=0: go to STEP and clear the counter. No strobe in the transition cycle.
- STEP:
  - `step_ev` asserts `cpu_en` for exactly 1 cycle.
  - Synced `run_sw`=1: go to RUN.
- HALTED:
  - Entered from RUN or STEP when `halt_req`=1.
  - Priority order is `halt_req` > `run_sw` change > strobe. A strobe due in the same cycle as `halt_req` is suppressed.
  - `cpu_en`=0 and `halted`=1 while in this state.
  - `step_ev` exits to IDLE. Exit happens even if `halt_req` is still high; the processor is expected to drop it once it has observed `halted`.
- `tick_cnt` increments on every cycle in which `cpu_en`=1.
- Divisor table entries of 0 are illegal. The block treats 0 as 1.

## Timing
- Reset values: `cpu_en`=0, `halted`=0, `state_o`=IDLE, `tick_cnt`=0. Synchronizers, debouncer, and divide counter are all 0.
- First RUN strobe: IDLE takes 1 cycle, then the strobe occurs at the end of the first full period. It lands div cycles after entering RUN.
- Step latency:
  - With debounce: the edge must pass the 2 synchronizer cycles and then hold stable for DEBOUNCE_CYCLES. `cpu_en` rises the cycle after that. Total is 2+DEBOUNCE_CYCLES+1 cycles from the raw rising edge.
  - Without debounce: 3 cycles from the raw rising edge.
- Button held high: exactly one `step_ev`. A new event requires a debounced release followed by a debounced press.
- Asserting `reset_n` low in the middle of a period or a debounce clears everything immediately. No strobe is emitted.
- `halt_req` to HALTED: 1 cycle. `halted` is a registered output and rises with the state change.

## Configuration
- `CPU_CLK_CTRL_DEBOUNCE_EN` defined: the debouncer is present. `step_btn` must hold a new level for DEBOUNCE_CYCLES before it is accepted.
- `CPU_CLK_CTRL_DEBOUNCE_EN` undefined: the debouncer is removed and the synchronized level feeds the edge detector directly. The `DEBOUNCE_CYCLES` parameter is ignored. This build is for simulation and for the 1-cycle bench.

## Structure
- Shared package `cpu_clk_pkg` holds:
  - the state enum (IDLE/RUN/STEP/HALTED);
  - the 4-entry divisor table `DIV_TABLE` = {28'd1, 28'd5, 28'd5000000, 28'd50000000};
  - the default `DEBOUNCE_CYCLES`.
- One sub-module, `btn_debounce`. It takes `clock_in`, `reset_n`, `din`, and produces `dout`, the debounced level. It contains the counter and the stable-level register. It is instantiated only under the macro.
- The synchronizers, edge detector, FSM, divide counter, and `tick_cnt` live in `cpu_clock_ctrl`.

## Test plan
- **Run at div 5.** Reset, then `run_sw`=1, `div_sel`=1. Expect `cpu_en` once every 5 cycles. `tick_cnt`=4 after 20 cycles in RUN.
- **Runtime divisor change.** In RUN with `div_sel`=1, switch to `div_sel`=0 mid-period. Expect the current 5-cycle period to complete, then `cpu_en` continuously high.
- **Step without debounce.** Macro off, `run_sw`=0. Pulse `step_btn` high for 10 cycles. Expect exactly one `cpu_en`, 3 cycles after the rising edge, and `tick_cnt`=1.
- **Step with debounce.** Macro on, DEBOUNCE_CYCLES=8. Apply bouncing input 1,0,1,0 every 2 cycles, then hold high. Expect one strobe, 11 cycles after the final rise.
- **Halt and resume.** In RUN at div 5, raise `halt_req` on the cycle a strobe is due. Expect no strobe, and `halted`=1 on the next cycle. A step event then returns the FSM to IDLE and then RUN.
- **Reset mid-operation.** Pull `reset_n` low at count 3 of 5. Expect all outputs 0 immediately, then a first strobe at the normal latency after release.
